// File: rtl/homomorphic_multiply_ctrl.sv
// Sequencer for one homomorphic_multiply instance: clears the multiplier, streams
// ciphertexts A and B from a 1-cycle operand memory, drains and captures results.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle clear pulse to the multiplier
// LOAD_A | read and issue A rows 0..DIMENSION
// LOAD_B | read and issue B rows 0..DIMENSION
// DRAIN  | issue rows DIMENSION+1..2*DIMENSION without memory reads
// FLUSH  | wait for the last result word to leave the output stage
module homomorphic_multiply_ctrl #(
  parameter int CIPHERTEXT_WIDTH = 21,
  parameter int DIMENSION        = 3,
  parameter int ROW_WIDTH        = DIMENSION + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ROW_WIDTH:0]          mem_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0] mem_rdata,
  output logic                        mult_clear,
  output logic                        mult_en,
  output logic [ROW_WIDTH-1:0]        mult_row,
  output logic                        mult_select,
  output logic [CIPHERTEXT_WIDTH-1:0] mult_entry,
  input  logic [CIPHERTEXT_WIDTH-1:0] mult_result,
  output logic                        res_valid,
  output logic [ROW_WIDTH-1:0]        res_index,
  output logic [CIPHERTEXT_WIDTH-1:0] res_data,
  output logic                        res_last
);

  localparam logic [ROW_WIDTH-1:0] ROW_LAST_LOAD   = ROW_WIDTH'(DIMENSION);
  localparam logic [ROW_WIDTH-1:0] ROW_FIRST_DRAIN = ROW_WIDTH'(DIMENSION + 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST        = ROW_WIDTH'(2 * DIMENSION);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN, FLUSH} state_t;

  state_t               state;
  logic                 iss;
  logic                 iss_rd;
  logic                 iss_sel;
  logic [ROW_WIDTH-1:0] iss_row;
  logic                 s1_rd;
  logic                 p_valid;
  logic [ROW_WIDTH-1:0] p_index;

  // The issue registers double as the memory request: data returns while the
  // same beat sits in stage 1, so it can be forwarded straight to the multiplier.
  assign mem_rd_en  = iss_rd;
  assign mem_addr   = {iss_sel, iss_row};
  assign mult_entry = s1_rd ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mult_clear  <= 1'b0;
      iss         <= 1'b0;
      iss_rd      <= 1'b0;
      iss_sel     <= 1'b0;
      iss_row     <= '0;
      mult_en     <= 1'b0;
      mult_row    <= '0;
      mult_select <= 1'b0;
      s1_rd       <= 1'b0;
      p_valid     <= 1'b0;
      p_index     <= '0;
      res_valid   <= 1'b0;
      res_index   <= '0;
      res_data    <= '0;
      res_last    <= 1'b0;
    end else begin
      mult_en     <= iss;
      mult_row    <= iss_row;
      mult_select <= iss_sel;
      s1_rd       <= iss_rd;

      // Only B and drain rows carry a finished partial; A rows just load.
      p_valid   <= mult_en && (mult_select || (mult_row > ROW_LAST_LOAD));
      p_index   <= mult_row;
      res_valid <= p_valid;
      res_index <= p_valid ? p_index : '0;
      res_data  <= p_valid ? mult_result : '0;
      res_last  <= p_valid && (p_index == ROW_LAST);
      done      <= p_valid && (p_index == ROW_LAST);

      mult_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            mult_clear <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= LOAD_A;
          iss     <= 1'b1;
          iss_rd  <= 1'b1;
          iss_sel <= 1'b0;
          iss_row <= '0;
        end
        LOAD_A: begin
          if (iss_row == ROW_LAST_LOAD) begin
            state   <= LOAD_B;
            iss_sel <= 1'b1;
            iss_row <= '0;
          end else begin
            iss_row <= iss_row + 1'b1;
          end
        end
        LOAD_B: begin
          if (iss_row == ROW_LAST_LOAD) begin
            state   <= DRAIN;
            iss_rd  <= 1'b0;
            iss_sel <= 1'b0;
            iss_row <= ROW_FIRST_DRAIN;
          end else begin
            iss_row <= iss_row + 1'b1;
          end
        end
        DRAIN: begin
          if (iss_row == ROW_LAST) begin
            state   <= FLUSH;
            iss     <= 1'b0;
            iss_row <= '0;
          end else begin
            iss_row <= iss_row + 1'b1;
          end
        end
        FLUSH: begin
          if (res_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
